// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the read-side FIFO packer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {FILL, STALL, FLUSH} pack_state_e;

  // Width needed to hold a lane count of 0..ratio.
  function automatic int unsigned count_w(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_out_reg.sv
// Single-entry valid/ready holding register for packed words.
module fifo_rd_out_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  output logic              free_c
);

  assign free_c = !out_valid || out_ready;

  // Payload only changes on load, so it holds steady while stalled.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_count <= load_count;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries (one-cycle read latency) and packs PACK_RATIO of them
// into a wide valid/ready word; flush drains a partial word marked last.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst_n,
  input  logic                             empty,
  output logic                             rd_en,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [count_w(PACK_RATIO)-1:0]   out_count,
  output logic                             out_last,
  output logic                             busy
);

  localparam int unsigned CW  = count_w(PACK_RATIO);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned WW  = DATA_WIDTH * PACK_RATIO;
  localparam logic [CW-1:0] FILL_FULL = CW'(PACK_RATIO);
  localparam logic [CW-1:0] FILL_LAST = CW'(PACK_RATIO - 1);

  typedef logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes_t;

  pack_state_e   state_q, state_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          inflight_q;
  logic          flush_pending_q, flush_pending_d;
  lanes_t        lanes_q, lanes_d, lanes_masked;
  logic [CW1-1:0] occupancy;

  logic          ld;
  lanes_t        ld_data;
  logic [CW-1:0] ld_count;
  logic          ld_last;
  logic          free_c;

  // Lanes already held plus the one returning from the FIFO.
  assign occupancy = {1'b0, fill_q} + CW1'(inflight_q);

  assign rd_en = rd_rst_n && !empty && (state_q == FILL) && !flush_pending_q &&
                 (occupancy < CW1'(PACK_RATIO));

  assign busy = (fill_q != '0) || inflight_q || out_valid || flush_pending_q;

  // Partial word with lanes at or above fill forced to zero.
  always_comb begin
    lanes_masked = '0;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      if (CW'(i) < fill_q) lanes_masked[i] = lanes_q[i];
    end
  end

  // Next-state and output-register load decode.
  always_comb begin
    state_d         = state_q;
    fill_d          = fill_q;
    lanes_d         = lanes_q;
    flush_pending_d = flush_pending_q || flush;
    ld              = 1'b0;
    ld_data         = lanes_q;
    ld_count        = FILL_FULL;
    ld_last         = 1'b0;
    case (state_q)
      FILL: begin
        if (inflight_q) begin
          for (int unsigned i = 0; i < PACK_RATIO; i++) begin
            if (CW'(i) == fill_q) lanes_d[i] = rd_data;
          end
          if (fill_q == FILL_LAST) begin
            if (free_c) begin
              ld      = 1'b1;
              ld_data = lanes_d;
              fill_d  = '0;
            end else begin
              fill_d  = FILL_FULL;
              state_d = STALL;
            end
          end else begin
            fill_d = fill_q + CW'(1);
          end
        end else if (flush_pending_q) begin
          state_d = FLUSH;
        end
      end
      STALL: begin
        if (free_c) begin
          ld      = 1'b1;
          fill_d  = '0;
          state_d = flush_pending_q ? FLUSH : FILL;
        end
      end
      FLUSH: begin
        if (free_c) begin
          ld              = (fill_q != '0);
          ld_data         = lanes_masked;
          ld_count        = fill_q;
          ld_last         = 1'b1;
          fill_d          = '0;
          flush_pending_d = 1'b0;
          state_d         = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q         <= FILL;
      fill_q          <= '0;
      inflight_q      <= 1'b0;
      flush_pending_q <= 1'b0;
      lanes_q         <= '0;
    end else begin
      state_q         <= state_d;
      fill_q          <= fill_d;
      inflight_q      <= rd_en;
      flush_pending_q <= flush_pending_d;
      lanes_q         <= lanes_d;
    end
  end

  fifo_rd_out_reg #(
    .DATA_W (WW),
    .CNT_W  (CW)
  ) u_out_reg (
    .rd_clk     (rd_clk),
    .rd_rst_n   (rd_rst_n),
    .load       (ld),
    .load_data  (ld_data),
    .load_count (ld_count),
    .load_last  (ld_last),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_last   (out_last),
    .free_c     (free_c)
  );

endmodule
